// File: rtl/fetch_pipe.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time, and registers {instruction, pc, pc+4} toward decode with stall/flush handling.
module fetch_pipe #(
  parameter int                DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  output logic              imem_req_do,
  output logic [DWIDTH-1:0] imem_addr_do,
  input  logic              imem_ack_di,
  input  logic [DWIDTH-1:0] imem_rdata_di,
  input  logic              stall_di,
  input  logic              flush_di,
  input  logic [DWIDTH-1:0] pc_target_di,
  output logic [DWIDTH-1:0] instruct_do,
  output logic [DWIDTH-1:0] pc_do,
  output logic [DWIDTH-1:0] pc_plus_do,
  output logic              fetch_busy_do
);

  localparam logic [DWIDTH-1:0] NOP     = DWIDTH'(32'h0000_0013);
  localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(4);

  // ISSUE: request in flight for fetch_pc_q. DRAIN: a redirected request is
  // still outstanding and its data will be thrown away. HOLD: one fetched word
  // parked in the skid while decode is stalled, no request outstanding.
  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e            state_q;
  logic [DWIDTH-1:0] fetch_pc_q;
  logic [DWIDTH-1:0] redirect_pc_q;
  logic [DWIDTH-1:0] skid_instr_q;
  logic [DWIDTH-1:0] skid_pc_q;
  logic [DWIDTH-1:0] instr_q;
  logic [DWIDTH-1:0] pc_q;
  logic [DWIDTH-1:0] pc_plus_q;

  logic              ack_eff;
  logic [DWIDTH-1:0] target_w;
  logic [DWIDTH-1:0] pc_inc_w;

  // Memory handshake: imem_req_do is the valid, imem_ack_di the ready/response.
  // A transfer completes on an edge where both are high; until then the
  // address is held constant, and an ack seen without a request is ignored.
  assign imem_req_do   = Rst_Core_N & (state_q != ST_HOLD);
  assign imem_addr_do  = fetch_pc_q;
  assign fetch_busy_do = imem_req_do & ~imem_ack_di;
  assign ack_eff       = imem_ack_di & imem_req_do;

  assign target_w = {pc_target_di[DWIDTH-1:2], 2'b00};
  assign pc_inc_w = fetch_pc_q + PC_STEP;

  assign instruct_do = instr_q;
  assign pc_do       = pc_q;
  assign pc_plus_do  = pc_plus_q;

  always_ff @(posedge Clk_Core) begin
    if (!Rst_Core_N) begin
      state_q       <= ST_ISSUE;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= '0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      instr_q       <= NOP;
      pc_q          <= '0;
      pc_plus_q     <= '0;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (ack_eff) begin
            if (flush_di) begin
              fetch_pc_q <= target_w;
              instr_q    <= NOP;
            end else if (stall_di) begin
              skid_instr_q <= imem_rdata_di;
              skid_pc_q    <= fetch_pc_q;
              fetch_pc_q   <= pc_inc_w;
              state_q      <= ST_HOLD;
            end else begin
              instr_q    <= imem_rdata_di;
              pc_q       <= fetch_pc_q;
              pc_plus_q  <= pc_inc_w;
              fetch_pc_q <= pc_inc_w;
            end
          end else begin
            if (flush_di) begin
              redirect_pc_q <= target_w;
              instr_q       <= NOP;
              state_q       <= ST_DRAIN;
            end else if (!stall_di) begin
              instr_q <= NOP;
            end
          end
        end

        ST_DRAIN: begin
          if (flush_di) begin
            redirect_pc_q <= target_w;
          end
          if (flush_di || !stall_di) begin
            instr_q <= NOP;
          end
          // A flush coinciding with the ack wins over the older redirect.
          if (ack_eff) begin
            fetch_pc_q <= flush_di ? target_w : redirect_pc_q;
            state_q    <= ST_ISSUE;
          end
        end

        ST_HOLD: begin
          if (flush_di) begin
            fetch_pc_q <= target_w;
            instr_q    <= NOP;
            state_q    <= ST_ISSUE;
          end else if (!stall_di) begin
            instr_q   <= skid_instr_q;
            pc_q      <= skid_pc_q;
            pc_plus_q <= skid_pc_q + PC_STEP;
            state_q   <= ST_ISSUE;
          end
        end

        default: state_q <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed bench for fetch_pipe: zero-wait and wait-state fetch, stall/skid,
// flush/drain, flush in HOLD, PC wrap and reset in the middle of a drain.
module tb_fetch_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk_Core;
  logic        Rst_Core_N;
  logic        imem_req_do;
  logic [31:0] imem_addr_do;
  logic        imem_ack_di;
  logic [31:0] imem_rdata_di;
  logic        stall_di;
  logic        flush_di;
  logic [31:0] pc_target_di;
  logic [31:0] instruct_do;
  logic [31:0] pc_do;
  logic [31:0] pc_plus_do;
  logic        fetch_busy_do;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pipe #(.DWIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .Clk_Core      (Clk_Core),
    .Rst_Core_N    (Rst_Core_N),
    .imem_req_do   (imem_req_do),
    .imem_addr_do  (imem_addr_do),
    .imem_ack_di   (imem_ack_di),
    .imem_rdata_di (imem_rdata_di),
    .stall_di      (stall_di),
    .flush_di      (flush_di),
    .pc_target_di  (pc_target_di),
    .instruct_do   (instruct_do),
    .pc_do         (pc_do),
    .pc_plus_do    (pc_plus_do),
    .fetch_busy_do (fetch_busy_do)
  );

  // clock / reset
  initial Clk_Core = 1'b0;
  always #5 Clk_Core = ~Clk_Core;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] pcp);
    chk({tag, "_ins"}, instruct_do, ins);
    chk({tag, "_pc"},  pc_do,       pc);
    chk({tag, "_pcp"}, pc_plus_do,  pcp);
  endtask

  // driver tasks
  task automatic drive(input logic ack, input logic stall, input logic flush,
                       input logic [31:0] tgt);
    imem_ack_di   = ack;
    stall_di      = stall;
    flush_di      = flush;
    pc_target_di  = tgt;
    imem_rdata_di = ack ? mem_word(imem_addr_do) : 32'hDEAD_BEEF;
  endtask

  task automatic tick;
    @(posedge Clk_Core);
    #1;
  endtask

  initial begin
    Rst_Core_N    = 1'b0;
    imem_ack_di   = 1'b0;
    imem_rdata_di = '0;
    stall_di      = 1'b0;
    flush_di      = 1'b0;
    pc_target_di  = '0;
    tick;
    tick;

    // reset: req forced low, ack ignored
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("rst_req", {31'b0, imem_req_do}, 32'd0);
    tick;
    chk_out("rst", NOP, 32'h0, 32'h0);

    // zero-wait fetch from RESET_PC
    Rst_Core_N = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("zw_req0", {31'b0, imem_req_do}, 32'd1);
    chk("zw_addr0", imem_addr_do, 32'h0);
    chk("zw_busy0", {31'b0, fetch_busy_do}, 32'd0);
    tick;
    chk_out("zw0", mem_word(32'h0), 32'h0, 32'h4);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("zw_addr1", imem_addr_do, 32'h4);
    tick;
    chk_out("zw1", mem_word(32'h4), 32'h4, 32'h8);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick;
    chk_out("zw2", mem_word(32'h8), 32'h8, 32'hC);

    // two-cycle latency at 0xC
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("wt_addr0", imem_addr_do, 32'hC);
    chk("wt_busy", {31'b0, fetch_busy_do}, 32'd1);
    tick;
    chk_out("wt_bub", NOP, 32'h8, 32'hC);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("wt_addr1", imem_addr_do, 32'hC);
    tick;
    chk_out("wt1", mem_word(32'hC), 32'hC, 32'h10);

    // stall for 3 cycles while the ack for 0x10 arrives
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    chk("st_addr", imem_addr_do, 32'h10);
    tick;
    chk_out("st0", mem_word(32'hC), 32'hC, 32'h10);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      #1;
      chk("st_req_hold", {31'b0, imem_req_do}, 32'd0);
      tick;
      chk_out("st_hold", mem_word(32'hC), 32'hC, 32'h10);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("st_req_rel", {31'b0, imem_req_do}, 32'd0);
    tick;
    chk_out("st_rel", mem_word(32'h10), 32'h10, 32'h14);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("st_next_req", {31'b0, imem_req_do}, 32'd1);
    chk("st_next_addr", imem_addr_do, 32'h14);
    tick;
    chk_out("st_next", mem_word(32'h14), 32'h14, 32'h18);

    // flush to 0x203 while request to 0x18 pending; ack two cycles later
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0203);
    tick;
    chk_out("fl0", NOP, 32'h14, 32'h18);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("fl_addr_hold0", imem_addr_do, 32'h18);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("fl_addr_hold1", imem_addr_do, 32'h18);
    tick;
    chk_out("fl_drop", NOP, 32'h14, 32'h18);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("fl_new_addr", imem_addr_do, 32'h200);
    tick;
    chk_out("fl_new", mem_word(32'h200), 32'h200, 32'h204);

    // second flush in DRAIN coinciding with ack takes the newer target
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0300);
    tick;
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0400);
    tick;
    chk_out("dr2", NOP, 32'h200, 32'h204);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0500);
    #1;
    chk("dr2_addr", imem_addr_do, 32'h400);
    tick;
    chk_out("isf", NOP, 32'h200, 32'h204);

    // flush + stall together in HOLD drops the skid
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    chk("hf_addr", imem_addr_do, 32'h500);
    tick;
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0600);
    tick;
    chk_out("hf", NOP, 32'h200, 32'h204);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("hf_req", {31'b0, imem_req_do}, 32'd1);
    chk("hf_addr2", imem_addr_do, 32'h600);
    tick;
    chk_out("hf_next", mem_word(32'h600), 32'h600, 32'h604);

    // sequential fetch across the top of the address space
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick;
    chk_out("wrap", mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);
    chk("wrap_addr", imem_addr_do, 32'h0);

    // reset for one cycle mid-DRAIN with fetch_pc = 0xFFFF_FFFC
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    tick;
    Rst_Core_N = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("mr_req", {31'b0, imem_req_do}, 32'd0);
    tick;
    Rst_Core_N = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("mr_addr", imem_addr_do, 32'h0);
    chk("mr_req_up", {31'b0, imem_req_do}, 32'd1);
    chk_out("mr", NOP, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick;
    chk_out("mr_next", mem_word(32'h0), 32'h0, 32'h4);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
